mem_responder: RTL
==================

# mem_responder

Word-addressed memory responder that terminates the multicycle processor's memory port (Adr, WriteData, MemWrite) and returns ReadData. It adds a request/ready handshake with a programmable number of wait states, so the controller can stall on MemReady. It also flags misaligned and out-of-range accesses. It sits between the processor top level and the unified instruction/data storage, replacing the zero-latency memory for wait-state experiments.

## Interface
- DEPTH, 64: storage size in 32-bit words; power of two, 4..1024.
- WAIT, 2: wait cycles inserted between request acceptance and response; 0..15.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset asserted), released synchronously by the system.
- MemReq  input  1  access request; held high by initiator until MemReady.
- MemWrite  input  1  1 = write, 0 = read; sampled with MemReq.
- Adr  input  32  byte address; must be stable while MemReq is high.
- WriteData  input  32  store data; stable while MemReq is high.
- ReadData  output  32  read data; valid in the MemReady cycle, held until the next read response.
- MemReady  output  1  one-cycle pulse completing the current access.
- MemErr  output  1  qualifies MemReady: access rejected (misaligned or out of range).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when MemReq=1, latch Adr, WriteData and MemWrite into request registers.
  - Go to WAIT with counter=WAIT-1 if WAIT>0.
  - Go directly to RESP if WAIT=0.
- WAIT: decrement the counter each cycle; go to RESP the cycle after the counter reaches 0.
- RESP: MemReady=1 for exactly one cycle, then go to IDLE unconditionally.
  - A MemReq still high in that IDLE cycle starts a new access. There is no back-to-back acceptance in RESP.
- Word index = latched Adr[log2(DEPTH)+1:2].
- Error = latched Adr[1:0]!=0, or latched Adr[31:log2(DEPTH)+2]!=0. On error:
  - MemErr=1 with MemReady.
  - No write occurs.
  - ReadData is forced to 32'h0000_0000.
- Read without error: ReadData is loaded from the array at the RESP edge and is registered, not combinational.
- Write without error: the array is updated at the RESP edge; ReadData is left unchanged.
- Changes to Adr, WriteData or MemWrite after acceptance are ignored, because only the latched copies are used.
- MemReq low in WAIT or RESP (initiator protocol violation) does not abort the access; the response still completes.

## Timing
- Latency from the accepting edge (IDLE, MemReq=1) to the MemReady cycle: WAIT+1 cycles.
- Throughput: one access per WAIT+2 cycles with MemReq held continuously.
- Reset values: state=IDLE, counter=0, ReadData=0, MemReady=0, MemErr=0, request registers=0.
- Array contents are not reset.
- Reset asserted mid-access aborts the access.
  - A write that has not reached its RESP edge is never committed.
  - A write whose RESP edge has already occurred stays committed.
- MemReady and MemErr are registered outputs with no combinational path from any input.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the WAIT counter width constant (4);
  - ERR_READDATA = 32'h0.
- Sub-module mem_array: DEPTH x 32 storage with synchronous write enable, index input and asynchronous read output. The responder registers the read output.
- The FSM, counter, request registers and error decode live in mem_responder.

## Test plan
- Reset, then WAIT=2, write 32'hDEADBEEF to Adr 32'h10, then read Adr 32'h10 -> write MemReady 3 cycles after acceptance with MemErr=0; read returns 32'hDEADBEEF with MemReady 3 cycles after acceptance.
- WAIT=0, back-to-back reads of Adr 0x0, 0x4 and 0x8 with MemReq held high -> MemReady every 2nd cycle, data in order.
- Misaligned write to Adr 32'h12 with data 32'h1234, then read Adr 32'h10 -> write returns MemErr=1; the earlier contents (32'hDEADBEEF) are unchanged.
- Out-of-range read at Adr 32'h100 with DEPTH=64 -> MemReady with MemErr=1 and ReadData=0.
- Write accepted, then reset asserted during WAIT, then read of the same word after release -> after reset the outputs are 0 and the state is IDLE; the read returns the old value, so the write was not committed.
- Adr and WriteData changed one cycle after acceptance -> the access uses the original values; the new values have no effect.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  localparam int          CNT_W        = 4;
  localparam logic [31:0] ERR_READDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage: synchronous write, asynchronous read at the same index.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and error flagging.
// Handshake: MemReq is held by the initiator until the one-cycle MemReady pulse; MemErr qualifies MemReady.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output mem_state_e  o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  mem_state_e         r_state;
  mem_state_e         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [31:0]        r_adr;
  logic [31:0]        r_wdata;
  logic               r_we;
  logic [31:0]        r_rdata;
  logic               r_ready;
  logic               r_err;

  logic               w_accept;
  logic               w_fire;
  logic [31:0]        w_adr;
  logic [31:0]        w_wdata;
  logic               w_we;
  logic               w_err;
  logic [AW-1:0]      w_idx;
  logic               w_mem_we;
  logic [31:0]        w_arr_rdata;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReq) begin
          w_accept = 1'b1;
          if (WAIT == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_RESP;
        else             w_cnt_next = r_cnt - CNT_W'(1);
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With WAIT=0 the RESP edge is also the accepting edge, so the live request is used there.
  assign w_adr   = (r_state == S_IDLE) ? Adr       : r_adr;
  assign w_wdata = (r_state == S_IDLE) ? WriteData : r_wdata;
  assign w_we    = (r_state == S_IDLE) ? MemWrite  : r_we;

  assign w_fire   = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_err    = (w_adr[1:0] != 2'b00) || (w_adr[31:AW+2] != '0);
  assign w_idx    = w_adr[AW+1:2];
  assign w_mem_we = w_fire && w_we && !w_err && reset;

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_idx  (w_idx),
    .i_wdata(w_wdata),
    .o_rdata(w_arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_adr   <= Adr;
        r_wdata <= WriteData;
        r_we    <= MemWrite;
      end
      r_ready <= w_fire;
      r_err   <= w_fire && w_err;
      if (w_fire) begin
        if (w_err)      r_rdata <= ERR_READDATA;
        else if (!w_we) r_rdata <= w_arr_rdata;
      end
    end
  end

  assign ReadData    = r_rdata;
  assign MemReady    = r_ready;
  assign MemErr      = r_err;
  assign o_dbg_state = r_state;

endmodule
